// File: rtl/mem_arbiter_if.sv
// Memory request/response bundle shared by fetch, data and the external port.
// master initiates requests; slave accepts them and returns the response.
interface mem_if;
  logic        mem_valid;
  logic        mem_fence;
  logic        mem_spec;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_valid, mem_fence, mem_spec, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_valid, mem_fence, mem_spec, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: data has fixed priority over instruction fetch,
// one transaction in flight, unissued pulses buffered with last-wins overwrite.
module mem_arbiter (
  input  logic     reset,
  input  logic     clock,
  mem_if.slave     imem,
  mem_if.slave     dmem,
  mem_if.master    mem
);

  typedef enum logic [1:0] {StIdle, StIBusy, StDBusy} state_e;

  typedef struct packed {
    logic        valid;
    logic        fence;
    logic        spec;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  state_e state_q, state_d;
  req_t   i_pend_q, i_pend_d;
  req_t   d_pend_q, d_pend_d;
  req_t   hold_q, hold_d;
  req_t   i_live, d_live, i_cand, d_cand, out_req;
  logic   arb_en;

  always_comb begin
    i_live = '{valid: imem.mem_valid, fence: imem.mem_fence, spec: imem.mem_spec,
               instr: imem.mem_instr, addr: imem.mem_addr, wdata: imem.mem_wdata,
               wstrb: imem.mem_wstrb};
    d_live = '{valid: dmem.mem_valid, fence: dmem.mem_fence, spec: dmem.mem_spec,
               instr: dmem.mem_instr, addr: dmem.mem_addr, wdata: dmem.mem_wdata,
               wstrb: dmem.mem_wstrb};
    i_cand = imem.mem_valid ? i_live : i_pend_q;
    d_cand = dmem.mem_valid ? d_live : d_pend_q;
  end

  always_comb begin
    state_d  = state_q;
    i_pend_d = i_pend_q;
    d_pend_d = d_pend_q;
    hold_d   = hold_q;
    out_req  = hold_q;
    out_req.valid = 1'b0;

    // A new pulse always replaces whatever is pending (fetch redirects rely on this).
    if (imem.mem_valid) i_pend_d = i_live;
    if (dmem.mem_valid) d_pend_d = d_live;

    // Reset gates arbitration so a dropped transaction cannot leak a ready or an issue.
    arb_en = reset && ((state_q == StIdle) || mem.mem_ready);

    if (arb_en) begin
      if (d_cand.valid) begin
        out_req        = d_cand;
        d_pend_d.valid = 1'b0;
        state_d        = StDBusy;
      end else if (i_cand.valid) begin
        out_req        = i_cand;
        i_pend_d.valid = 1'b0;
        state_d        = StIBusy;
      end else begin
        out_req = '0;
        state_d = StIdle;
      end
      hold_d = out_req;
    end

    if (!reset) out_req = '0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= StIdle;
      i_pend_q <= '0;
      d_pend_q <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      i_pend_q <= i_pend_d;
      d_pend_q <= d_pend_d;
      hold_q   <= hold_d;
    end
  end

  assign mem.mem_valid = out_req.valid;
  assign mem.mem_fence = out_req.fence;
  assign mem.mem_spec  = out_req.spec;
  assign mem.mem_instr = out_req.instr;
  assign mem.mem_addr  = out_req.addr;
  assign mem.mem_wdata = out_req.wdata;
  assign mem.mem_wstrb = out_req.wstrb;

  assign imem.mem_rdata = mem.mem_rdata;
  assign dmem.mem_rdata = mem.mem_rdata;
  assign imem.mem_ready = reset && (state_q == StIBusy) && mem.mem_ready;
  assign dmem.mem_ready = reset && (state_q == StDBusy) && mem.mem_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change just after the falling edge,
// outputs are checked 1 ns later, well before the next rising edge.
module tb_mem_arbiter;

  logic reset;
  logic clock;
  int   n_checks;
  int   n_fail;

  mem_if i_bus ();
  mem_if d_bus ();
  mem_if m_bus ();

  mem_arbiter dut (
    .reset (reset),
    .clock (clock),
    .imem  (i_bus),
    .dmem  (d_bus),
    .mem   (m_bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_i(input logic v, input logic [31:0] addr, input logic spec);
    i_bus.mem_valid = v;
    i_bus.mem_fence = 1'b0;
    i_bus.mem_spec  = spec;
    i_bus.mem_instr = v;
    i_bus.mem_addr  = addr;
    i_bus.mem_wdata = '0;
    i_bus.mem_wstrb = '0;
  endtask

  task automatic drive_d(input logic v, input logic [31:0] addr, input logic [3:0] wstrb);
    d_bus.mem_valid = v;
    d_bus.mem_fence = 1'b0;
    d_bus.mem_spec  = 1'b0;
    d_bus.mem_instr = 1'b0;
    d_bus.mem_addr  = addr;
    d_bus.mem_wdata = 32'hcafe_0000 | addr;
    d_bus.mem_wstrb = wstrb;
  endtask

  task automatic drive_m(input logic rdy, input logic [31:0] rdata);
    m_bus.mem_ready = rdy;
    m_bus.mem_rdata = rdata;
  endtask

  // Advance to the next falling edge; caller then drives and waits 1 ns.
  task automatic next_cycle();
    @(negedge clock);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    drive_i(1'b0, '0, 1'b0);
    drive_d(1'b0, '0, '0);
    drive_m(1'b0, '0);

    // Reset held with mem_ready toggling.
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      drive_m(k[0], 32'h1234_5678);
      #1;
      check("rst_valid", {31'd0, m_bus.mem_valid}, 32'd0);
      check("rst_iready", {31'd0, i_bus.mem_ready}, 32'd0);
      check("rst_dready", {31'd0, d_bus.mem_ready}, 32'd0);
    end
    check("rst_addr", m_bus.mem_addr, 32'd0);
    next_cycle();
    reset = 1'b1;
    drive_m(1'b0, '0);

    // Single instruction fetch.
    next_cycle();
    drive_i(1'b1, 32'h100, 1'b0);
    #1;
    check("if_valid", {31'd0, m_bus.mem_valid}, 32'd1);
    check("if_addr", m_bus.mem_addr, 32'h100);
    check("if_instr", {31'd0, m_bus.mem_instr}, 32'd1);
    next_cycle();
    drive_i(1'b0, '0, 1'b0);
    #1;
    check("if_busy_valid", {31'd0, m_bus.mem_valid}, 32'd0);
    check("if_busy_addr", m_bus.mem_addr, 32'h100);
    check("if_busy_iready", {31'd0, i_bus.mem_ready}, 32'd0);
    next_cycle();
    drive_m(1'b1, 32'h0000_0013);
    #1;
    check("if_iready", {31'd0, i_bus.mem_ready}, 32'd1);
    check("if_irdata", i_bus.mem_rdata, 32'h0000_0013);
    check("if_dready", {31'd0, d_bus.mem_ready}, 32'd0);
    check("if_end_valid", {31'd0, m_bus.mem_valid}, 32'd0);
    next_cycle();
    drive_m(1'b0, '0);
    #1;
    check("if_after_iready", {31'd0, i_bus.mem_ready}, 32'd0);

    // Collision: data wins, fetch issues in data's ready cycle.
    next_cycle();
    drive_i(1'b1, 32'h200, 1'b0);
    drive_d(1'b1, 32'h8000, 4'hF);
    #1;
    check("col_valid", {31'd0, m_bus.mem_valid}, 32'd1);
    check("col_daddr", m_bus.mem_addr, 32'h8000);
    check("col_wstrb", {28'd0, m_bus.mem_wstrb}, 32'hF);
    next_cycle();
    drive_i(1'b0, '0, 1'b0);
    drive_d(1'b0, '0, '0);
    drive_m(1'b1, 32'h0);
    #1;
    check("col_dready", {31'd0, d_bus.mem_ready}, 32'd1);
    check("col_iready0", {31'd0, i_bus.mem_ready}, 32'd0);
    check("col_ivalid", {31'd0, m_bus.mem_valid}, 32'd1);
    check("col_iaddr", m_bus.mem_addr, 32'h200);
    next_cycle();
    drive_m(1'b0, '0);
    #1;
    check("col_busy_valid", {31'd0, m_bus.mem_valid}, 32'd0);
    next_cycle();
    drive_m(1'b1, 32'hdead_beef);
    #1;
    check("col_iready", {31'd0, i_bus.mem_ready}, 32'd1);
    check("col_dready0", {31'd0, d_bus.mem_ready}, 32'd0);

    // Overwrite: last fetch pulse during data busy wins.
    next_cycle();
    drive_m(1'b0, '0);
    drive_d(1'b1, 32'h9000, 4'h0);
    #1;
    check("ow_dissue", m_bus.mem_addr, 32'h9000);
    next_cycle();
    drive_d(1'b0, '0, '0);
    drive_i(1'b1, 32'h300, 1'b0);
    #1;
    check("ow_busy1", {31'd0, m_bus.mem_valid}, 32'd0);
    next_cycle();
    drive_i(1'b1, 32'h400, 1'b1);
    #1;
    check("ow_busy2", {31'd0, m_bus.mem_valid}, 32'd0);
    next_cycle();
    drive_i(1'b0, '0, 1'b0);
    drive_m(1'b1, 32'h0);
    #1;
    check("ow_ivalid", {31'd0, m_bus.mem_valid}, 32'd1);
    check("ow_iaddr", m_bus.mem_addr, 32'h400);
    check("ow_spec", {31'd0, m_bus.mem_spec}, 32'd1);
    next_cycle();
    #1;
    check("ow_iready", {31'd0, i_bus.mem_ready}, 32'd1);
    check("ow_no_300", {31'd0, m_bus.mem_valid}, 32'd0);

    // Back-to-back data: each request pulsed in its predecessor's ready cycle.
    next_cycle();
    drive_m(1'b0, '0);
    #1;
    check("b2b_idle", {31'd0, m_bus.mem_valid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      drive_d(1'b1, 32'hA000 + 32'(4 * k), 4'h0);
      drive_m(k != 0, 32'h0);
      #1;
      check("b2b_valid", {31'd0, m_bus.mem_valid}, 32'd1);
      check("b2b_addr", m_bus.mem_addr, 32'hA000 + 32'(4 * k));
      check("b2b_dready", {31'd0, d_bus.mem_ready}, {31'd0, k != 0});
      next_cycle();
      drive_d(1'b0, '0, '0);
      drive_m(1'b0, '0);
      #1;
      check("b2b_gap", {31'd0, m_bus.mem_valid}, 32'd0);
    end
    next_cycle();
    drive_m(1'b1, 32'h0);
    #1;
    check("b2b_last_ready", {31'd0, d_bus.mem_ready}, 32'd1);

    // Reset during an instruction transaction, then a late ready.
    next_cycle();
    drive_m(1'b0, '0);
    drive_i(1'b1, 32'h500, 1'b0);
    #1;
    check("mr_issue", m_bus.mem_addr, 32'h500);
    next_cycle();
    drive_i(1'b0, '0, 1'b0);
    reset = 1'b0;
    drive_m(1'b1, 32'h0);
    #1;
    check("mr_rst_iready", {31'd0, i_bus.mem_ready}, 32'd0);
    check("mr_rst_valid", {31'd0, m_bus.mem_valid}, 32'd0);
    next_cycle();
    reset = 1'b1;
    #1;
    check("mr_late_iready", {31'd0, i_bus.mem_ready}, 32'd0);
    check("mr_late_dready", {31'd0, d_bus.mem_ready}, 32'd0);
    next_cycle();
    drive_m(1'b0, '0);
    drive_i(1'b1, 32'h600, 1'b0);
    #1;
    check("mr_idle_issue", {31'd0, m_bus.mem_valid}, 32'd1);
    check("mr_idle_addr", m_bus.mem_addr, 32'h600);
    next_cycle();
    drive_i(1'b0, '0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one memory port between the instruction fetch interface and the data access interface. It sits between the fetch stage, the memory stage and the single external memory or bus port. It accepts single-cycle `mem_valid` request pulses from either side and buffers any request it cannot issue immediately. It issues one transaction at a time and routes each response back to its owner.

## Interface
- No parameters.
- reset  in  1  synchronous, active-low reset
- clock  in  1  clock
- imem_in  in  mem_in_type  instruction requests: mem_valid pulse, mem_fence, mem_spec, mem_instr, mem_addr[31:0], mem_wdata[31:0], mem_wstrb[3:0]
- imem_out  out  mem_out_type  instruction response: mem_rdata[31:0], mem_ready
- dmem_in  in  mem_in_type  data requests, same fields
- dmem_out  out  mem_out_type  data response
- mem_in  out  mem_in_type  shared port request
- mem_out  in  mem_out_type  shared port response

## Operation
- State machine `idle`, `ibusy`, `dbusy`. One pending register per requester holds a valid bit plus all mem_in_type fields.
- Request capture:
  - A requester's `mem_valid=1` that is not issued in the same cycle is latched into its pending register.
  - A new pulse from the same requester while its request is still pending overwrites that request. This is the last-wins rule; it serves fetch redirects with mem_spec=1.
- Issue candidates: the live input pulse if present, else the pending register.
- Arbitration applies when state is `idle`, or in the cycle `mem_out.mem_ready=1` ends the current transaction:
  - A data candidate wins over an instruction candidate (fixed priority).
  - The winner drives `mem_in` with `mem_valid=1` for exactly one cycle, and its pending bit clears.
  - State moves to `dbusy` or `ibusy`.
  - With no candidate, state goes to `idle` and `mem_in` is driven all-zero.
- While busy:
  - `mem_in.mem_valid=0`; the other request fields hold the issued values.
  - Pulses arriving during busy are latched.
- Response routing:
  - `mem_rdata` is forwarded to both outputs.
  - `mem_ready` goes only to the owner (`ibusy` to imem_out, `dbusy` to dmem_out). The non-owner sees ready=0.
  - In `idle`, both ready outputs are 0.
- An in-flight transaction is never cancelled. Fence and spec bits pass through unchanged; discarding a response is the requester's job.
- The sole starvation bound is that instruction requests wait behind consecutive data requests. This is accepted because data traffic is pipeline-bounded.

## Timing
- Reset (reset=0 at a clock edge):
  - state=`idle`, both pending bits=0.
  - mem_in all-zero, imem_out/dmem_out ready=0.
  - rdata is a combinational passthrough of mem_out.mem_rdata, so it is not forced by reset.
- Reset asserted mid-transaction:
  - The transaction is dropped, with no ready delivered to its owner.
  - A late mem_ready arriving in `idle` is ignored.
- Latency with state idle and no pending request: a request pulse in cycle N drives mem_in.mem_valid in cycle N (combinational issue). The response appears in the cycle mem_out.mem_ready=1.
- Back-to-back: in the ready cycle of transaction A, the next candidate issues in that same cycle. There are no bubble cycles.
- Simultaneous pulses in cycle N from idle: data issues in N and instruction is latched. Instruction issues in the cycle data's ready arrives.
- A pulse in the same cycle as ready from the current owner is eligible for arbitration in that cycle.
- The pending register updates on clock. Issue decisions are combinational from state, pending and live inputs.

## Test plan
- Reset: hold reset=0 for 3 cycles with mem_ready toggling -> mem_in.mem_valid=0 and both ready outputs=0 throughout.
- Single instruction fetch:
  - Stimulus: imem pulse with addr 0x100 in cycle 2; mem_ready=1 in cycle 4 with rdata 0x00000013.
  - Response: mem_valid=1 in cycle 2 only; imem_out.ready=1 in cycle 4 only with rdata 0x00000013; dmem_out.ready stays 0.
- Collision:
  - Stimulus: in cycle 2, imem addr 0x200 and dmem store addr 0x8000 with wstrb 0xF; ready in cycles 3 and 5.
  - Response: data issues in cycle 2 and instruction in cycle 3; dmem ready in cycle 3, imem ready in cycle 5.
- Overwrite:
  - Stimulus: while data is busy, imem pulses addr 0x300, then addr 0x400 with spec=1.
  - Response: only 0x400 is issued, with mem_spec=1.
- Back-to-back data: 4 dmem requests each pulsed in their predecessor's ready cycle -> 4 issues with no idle gaps.
- Mid-transaction reset:
  - Stimulus: reset during `ibusy`, then a late mem_ready.
  - Response: no imem_out.ready, and state returns to `idle`.
